// File: rtl/mpt_pkg.sv
// Shared MPT walker types: PLB lookup request, access-type encoding and PLB entry layout.
package mpt_pkg;

  localparam int unsigned SDID_WIDTH = 6;
  localparam int unsigned SPA_WIDTH  = 34;

  typedef enum logic [1:0] {
    ACCESS_READ  = 2'd0,
    ACCESS_WRITE = 2'd1,
    ACCESS_EXEC  = 2'd2
  } access_type_e;

  typedef struct packed {
    logic [SDID_WIDTH-1:0] sdid;
    logic [SPA_WIDTH-1:0]  spa;
    access_type_e          access_type;
  } plb_lookup_req_t;

  localparam int unsigned PLB_PERM_R     = 0;
  localparam int unsigned PLB_PERM_W     = 1;
  localparam int unsigned PLB_PERM_X     = 2;
  localparam int unsigned PLB_PERM_WIDTH = 3;

  // Page number is held at full SPA width so any page offset fits without truncation.
  typedef struct packed {
    logic [SDID_WIDTH-1:0] sdid;
    logic [SPA_WIDTH-1:0]  page;
  } plb_tag_t;

  typedef struct packed {
    logic                      valid;
    plb_tag_t                  tag;
    logic [PLB_PERM_WIDTH-1:0] perm;
  } plb_entry_t;

  function automatic plb_tag_t plb_make_tag(input plb_lookup_req_t req,
                                            input int unsigned page_offset);
    plb_tag_t tag;
    tag.sdid = req.sdid;
    tag.page = req.spa >> page_offset;
    return tag;
  endfunction

endpackage

// File: rtl/plb_cache_replacement.sv
// PLB insert slot selection: lowest free entry first, otherwise a round-robin victim.
module plb_replacement #(
  parameter int unsigned NUM_ENTRIES = 8,
  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_ENTRIES-1:0] valid_i,
  input  logic                   alloc_i,
  output logic [IDX_W-1:0]       idx_c
);

  logic [IDX_W-1:0] victim_q;
  logic [IDX_W-1:0] free_idx;
  logic             free_found;

  // Scan downward so the last assignment wins with the lowest free index.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  assign idx_c = free_found ? free_idx : victim_q;

  // Victim only advances when it was actually consumed; wraps naturally (power of two).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      victim_q <= '0;
    end else if (alloc_i && !free_found) begin
      victim_q <= victim_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/plb_cache.sv
// Permission Lookaside Buffer: fully associative {SDID, page} -> R/W/X store on a MEM slave port.
module plb_cache
  import mpt_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES       = 8,
  parameter int unsigned PAGE_OFFSET_WIDTH = 12,
  localparam int unsigned PLB_REQ_WIDTH    = $bits(plb_lookup_req_t)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     plb_cache_mem_req,
  output logic                     plb_cache_mem_gnt,
  input  logic                     plb_cache_mem_we,
  input  logic [PLB_REQ_WIDTH-1:0] plb_cache_mem_addr,
  input  logic [PLB_REQ_WIDTH-1:0] plb_cache_mem_wdata,
  output logic                     plb_cache_mem_valid,
  output logic [PLB_REQ_WIDTH-1:0] plb_cache_mem_data,
  input  logic                     plb_flush_all_i,
  input  logic                     plb_flush_sdid_i,
  input  logic [SDID_WIDTH-1:0]    plb_flush_sdid_val_i
);

  localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

  plb_entry_t                entries_q [NUM_ENTRIES];
  plb_lookup_req_t           req;
  plb_tag_t                  req_tag;
  logic [NUM_ENTRIES-1:0]    valid_vec;
  logic                      match_any;
  logic [IDX_W-1:0]          match_idx;
  logic                      hit_c;
  logic [PLB_PERM_WIDTH-1:0] need_perm;
  logic [IDX_W-1:0]          repl_idx;
  logic [IDX_W-1:0]          write_idx;
  logic                      lookup_fire;
  logic                      insert_fire;
  logic                      rsp_valid_q;
  logic                      rsp_hit_q;
  logic                      unused_wdata;

  assign req     = plb_lookup_req_t'(plb_cache_mem_addr);
  assign req_tag = plb_make_tag(req, PAGE_OFFSET_WIDTH);

  assign plb_cache_mem_gnt = plb_cache_mem_req && !plb_flush_all_i && !plb_flush_sdid_i;
  assign lookup_fire       = plb_cache_mem_gnt && !plb_cache_mem_we;
  assign insert_fire       = plb_cache_mem_gnt && plb_cache_mem_we;

  assign unused_wdata = ^plb_cache_mem_wdata[PLB_REQ_WIDTH-1:PLB_PERM_WIDTH];

  // Permission bit demanded by the access type; unknown encodings demand nothing and miss.
  always_comb begin
    need_perm = '0;
    case (req.access_type)
      ACCESS_READ:  need_perm[PLB_PERM_R] = 1'b1;
      ACCESS_WRITE: need_perm[PLB_PERM_W] = 1'b1;
      ACCESS_EXEC:  need_perm[PLB_PERM_X] = 1'b1;
      default:      need_perm = '0;
    endcase
  end

  // Tag compare across all entries; a tag match without the permission is still a miss.
  always_comb begin
    valid_vec = '0;
    match_any = 1'b0;
    match_idx = '0;
    hit_c     = 1'b0;
    for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
      valid_vec[i] = entries_q[i].valid;
      if (entries_q[i].valid && (entries_q[i].tag == req_tag)) begin
        match_any = 1'b1;
        match_idx = IDX_W'(i);
        if (|(entries_q[i].perm & need_perm)) begin
          hit_c = 1'b1;
        end
      end
    end
  end

  plb_replacement #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_replacement (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_vec),
    .alloc_i (insert_fire && !match_any),
    .idx_c   (repl_idx)
  );

  assign write_idx = match_any ? match_idx : repl_idx;

  // Flushes never coincide with an insert because they drop the grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
    end else if (plb_flush_all_i) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        entries_q[i].valid <= 1'b0;
      end
    end else if (plb_flush_sdid_i) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        if (entries_q[i].tag.sdid == plb_flush_sdid_val_i) begin
          entries_q[i].valid <= 1'b0;
        end
      end
    end else if (insert_fire) begin
      entries_q[write_idx].valid <= 1'b1;
      entries_q[write_idx].tag   <= req_tag;
      entries_q[write_idx].perm  <= plb_cache_mem_wdata[PLB_PERM_WIDTH-1:0];
    end
  end

  // Every grant yields exactly one response next cycle; inserts answer with zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
    end else begin
      rsp_valid_q <= plb_cache_mem_gnt;
      rsp_hit_q   <= lookup_fire && hit_c;
    end
  end

  assign plb_cache_mem_valid = rsp_valid_q;
  assign plb_cache_mem_data  = PLB_REQ_WIDTH'(rsp_hit_q);

endmodule

// File: tb/tb_plb_cache.sv
// Directed bench for plb_cache: vector table for basic lookup/insert, hand sequences for corners.
module tb_plb_cache;
  import mpt_pkg::*;

  localparam int unsigned W = $bits(plb_lookup_req_t);

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req;
  logic         gnt;
  logic         we;
  logic [W-1:0] addr;
  logic [W-1:0] wdata;
  logic         rvalid;
  logic [W-1:0] rdata;
  logic         flush_all;
  logic         flush_sdid;
  logic [SDID_WIDTH-1:0] flush_val;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  plb_cache #(
    .NUM_ENTRIES(8),
    .PAGE_OFFSET_WIDTH(12)
  ) dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .plb_cache_mem_req    (req),
    .plb_cache_mem_gnt    (gnt),
    .plb_cache_mem_we     (we),
    .plb_cache_mem_addr   (addr),
    .plb_cache_mem_wdata  (wdata),
    .plb_cache_mem_valid  (rvalid),
    .plb_cache_mem_data   (rdata),
    .plb_flush_all_i      (flush_all),
    .plb_flush_sdid_i     (flush_sdid),
    .plb_flush_sdid_val_i (flush_val)
  );

  typedef struct {
    logic                  we;
    logic [SDID_WIDTH-1:0] sdid;
    logic [SPA_WIDTH-1:0]  spa;
    access_type_e          acc;
    logic [2:0]            perm;
    logic                  exp_hit;
    string                 name;
  } vec_t;

  vec_t vecs [10];

  function automatic vec_t mk(input logic w, input logic [SDID_WIDTH-1:0] s,
                              input logic [SPA_WIDTH-1:0] a, input access_type_e t,
                              input logic [2:0] p, input logic h, input string n);
    vec_t v;
    v.we = w; v.sdid = s; v.spa = a; v.acc = t; v.perm = p; v.exp_hit = h; v.name = n;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_addr(input logic [SDID_WIDTH-1:0] sdid, input logic [SPA_WIDTH-1:0] spa,
                          input access_type_e acc);
    plb_lookup_req_t r;
    r.sdid = sdid;
    r.spa = spa;
    r.access_type = acc;
    addr = r;
  endtask

  // One granted transfer; consecutive calls produce back-to-back grants.
  task automatic xfer(input logic w, input logic [SDID_WIDTH-1:0] sdid,
                      input logic [SPA_WIDTH-1:0] spa, input access_type_e acc,
                      input logic [2:0] perm, input logic exp_hit, input string name);
    @(negedge clk_i);
    req = 1'b1;
    we = w;
    set_addr(sdid, spa, acc);
    wdata = W'(perm);
    #1 chk({name, "_gnt"}, 64'(gnt), 64'd1);
    @(posedge clk_i);
    #1;
    req = 1'b0;
    chk({name, "_valid"}, 64'(rvalid), 64'd1);
    chk({name, "_data"}, 64'(rdata), w ? 64'd0 : 64'(exp_hit));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    req = 1'b0;
    flush_all = 1'b0;
    flush_sdid = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni = 1'b0;
    req = 1'b0;
    we = 1'b0;
    addr = '0;
    wdata = '0;
    flush_all = 1'b0;
    flush_sdid = 1'b0;
    flush_val = '0;
    #1;
    chk("reset_valid", 64'(rvalid), 64'd0);
    chk("reset_data", 64'(rdata), 64'd0);
    chk("reset_gnt_idle", 64'(gnt), 64'd0);
    do_reset();

    vecs[0] = mk(1'b0, 6'd3, 34'h0_8000_1234, ACCESS_READ,  3'b000, 1'b0, "cold_miss");
    vecs[1] = mk(1'b1, 6'd3, 34'h0_8000_1000, ACCESS_READ,  3'b001, 1'b0, "ins_r");
    vecs[2] = mk(1'b0, 6'd3, 34'h0_8000_1FFC, ACCESS_READ,  3'b000, 1'b1, "rd_hit");
    vecs[3] = mk(1'b0, 6'd3, 34'h0_8000_1FFC, ACCESS_WRITE, 3'b000, 1'b0, "wr_noperm");
    vecs[4] = mk(1'b0, 6'd4, 34'h0_8000_1FFC, ACCESS_READ,  3'b000, 1'b0, "other_sdid");
    vecs[5] = mk(1'b0, 6'd3, 34'h0_8000_1FFC, ACCESS_EXEC,  3'b000, 1'b0, "ex_noperm");
    vecs[6] = mk(1'b1, 6'd3, 34'h0_8000_1000, ACCESS_READ,  3'b110, 1'b0, "reins_wx");
    vecs[7] = mk(1'b0, 6'd3, 34'h0_8000_1004, ACCESS_READ,  3'b000, 1'b0, "reins_rd_miss");
    vecs[8] = mk(1'b0, 6'd3, 34'h0_8000_1004, ACCESS_WRITE, 3'b000, 1'b1, "reins_wr_hit");
    vecs[9] = mk(1'b0, 6'd3, 34'h0_8000_1004, ACCESS_EXEC,  3'b000, 1'b1, "reins_ex_hit");
    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].we, vecs[i].sdid, vecs[i].spa, vecs[i].acc, vecs[i].perm,
           vecs[i].exp_hit, vecs[i].name);
    end

    // Fill past capacity: pages 8,9 take entries 0,1, victim ends at 2.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      xfer(1'b1, 6'd5, 34'h1000_0000 + 34'(k) * 34'h1000, ACCESS_READ, 3'b111, 1'b0,
           $sformatf("evict_ins%0d", k));
    end
    for (int k = 0; k < 10; k++) begin
      xfer(1'b0, 6'd5, 34'h1000_0010 + 34'(k) * 34'h1000, ACCESS_READ, 3'b000, k >= 2,
           $sformatf("evict_lk%0d", k));
    end
    xfer(1'b1, 6'd5, 34'h1000_5000, ACCESS_READ, 3'b110, 1'b0, "upd_ins");
    xfer(1'b0, 6'd5, 34'h1000_5000, ACCESS_READ, 3'b000, 1'b0, "upd_rd");
    for (int k = 2; k < 10; k++) begin
      xfer(1'b0, 6'd5, 34'h1000_0000 + 34'(k) * 34'h1000, ACCESS_WRITE, 3'b000, 1'b1,
           $sformatf("upd_keep%0d", k));
    end
    // Next full-array insert must take entry 2 (page 2).
    xfer(1'b1, 6'd5, 34'h1000_A000, ACCESS_READ, 3'b001, 1'b0, "vict_ins");
    xfer(1'b0, 6'd5, 34'h1000_2000, ACCESS_READ, 3'b000, 1'b0, "vict_p2_gone");
    xfer(1'b0, 6'd5, 34'h1000_3000, ACCESS_READ, 3'b000, 1'b1, "vict_p3_kept");
    xfer(1'b0, 6'd5, 34'h1000_A000, ACCESS_READ, 3'b000, 1'b1, "vict_p10_hit");

    // Insert then lookup in consecutive cycles, then one idle cycle.
    xfer(1'b1, 6'd3, 34'h4000_0000, ACCESS_READ, 3'b001, 1'b0, "b2b_ins");
    xfer(1'b0, 6'd3, 34'h4000_0000, ACCESS_READ, 3'b000, 1'b1, "b2b_lk");
    @(posedge clk_i);
    #1 chk("idle_valid", 64'(rvalid), 64'd0);
    xfer(1'b1, 6'd3, 34'h4000_1000, ACCESS_READ, 3'b001, 1'b0, "ins_y");
    xfer(1'b0, 6'd5, 34'h1000_6000, ACCESS_READ, 3'b000, 1'b1, "preflush_p6");

    // SDID flush with a live request: no grant, no response.
    @(negedge clk_i);
    req = 1'b1;
    we = 1'b0;
    set_addr(6'd3, 34'h4000_0000, ACCESS_READ);
    flush_sdid = 1'b1;
    flush_val = 6'd3;
    #1 chk("flush_sdid_gnt", 64'(gnt), 64'd0);
    @(posedge clk_i);
    #1;
    chk("flush_sdid_valid", 64'(rvalid), 64'd0);
    req = 1'b0;
    flush_sdid = 1'b0;
    xfer(1'b0, 6'd3, 34'h4000_0000, ACCESS_READ, 3'b000, 1'b0, "fs_x_miss");
    xfer(1'b0, 6'd3, 34'h4000_1000, ACCESS_READ, 3'b000, 1'b0, "fs_y_miss");
    xfer(1'b0, 6'd5, 34'h1000_6000, ACCESS_READ, 3'b000, 1'b1, "fs_p6_hit");
    xfer(1'b0, 6'd5, 34'h1000_A000, ACCESS_READ, 3'b000, 1'b1, "fs_p10_hit");
    xfer(1'b0, 6'd5, 34'h1000_5000, ACCESS_WRITE, 3'b000, 1'b1, "fs_p5_hit");

    // Both flushes together: flush-all wins, so a non-matching SDID is cleared too.
    xfer(1'b1, 6'd7, 34'h2200_0000, ACCESS_READ, 3'b111, 1'b0, "fa_ins");
    @(negedge clk_i);
    req = 1'b1;
    set_addr(6'd7, 34'h2200_0000, ACCESS_READ);
    flush_all = 1'b1;
    flush_sdid = 1'b1;
    flush_val = 6'd3;
    #1 chk("flush_all_gnt", 64'(gnt), 64'd0);
    @(posedge clk_i);
    #1;
    req = 1'b0;
    flush_all = 1'b0;
    flush_sdid = 1'b0;
    xfer(1'b0, 6'd7, 34'h2200_0000, ACCESS_READ, 3'b000, 1'b0, "fa_z_miss");
    xfer(1'b0, 6'd5, 34'h1000_6000, ACCESS_READ, 3'b000, 1'b0, "fa_p6_miss");

    // Reset lands while a lookup response is pending.
    xfer(1'b1, 6'd2, 34'h3000_0000, ACCESS_READ, 3'b001, 1'b0, "rst_ins");
    xfer(1'b0, 6'd2, 34'h3000_0000, ACCESS_READ, 3'b000, 1'b1, "rst_pre_hit");
    @(negedge clk_i);
    req = 1'b1;
    we = 1'b0;
    set_addr(6'd2, 34'h3000_0000, ACCESS_READ);
    #1 chk("rst_lk_gnt", 64'(gnt), 64'd1);
    #3 rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rst_drop_valid", 64'(rvalid), 64'd0);
    chk("rst_drop_data", 64'(rdata), 64'd0);
    req = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1 chk("rst_after_valid", 64'(rvalid), 64'd0);
    xfer(1'b0, 6'd2, 34'h3000_0000, ACCESS_READ, 3'b000, 1'b0, "rst_post_miss");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
